// File: rtl/hamming_13_8_decoder.sv
// SECDED (13,8) Hamming decoder with a single registered, backpressured output stage.
// Error counters exist only when HAMMING_ERR_CNT_EN is defined; otherwise they read 0.
module hamming_13_8_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      in_cw,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_corrected,
  output logic             out_uncorr,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  logic [3:0]  syn;
  logic        pe;
  logic [12:0] fixed_cw;
  logic [7:0]  dec_data;
  logic        dec_corr;
  logic        dec_uncorr;
  logic        take;

  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_corr_q, out_corr_d;
  logic        out_uncorr_q, out_uncorr_d;

  // Syndrome is the XOR of the indices of every set Hamming position.
  always_comb begin
    syn = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      if (in_cw[i-1]) syn = syn ^ 4'(i);
    end
    pe = ^in_cw;
  end

  // NOTE: every variable gets a default before the if-tree so no latch is inferred.
  always_comb begin
    fixed_cw   = in_cw;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    if (pe) begin
      if (syn == 4'd0) begin
        dec_corr = 1'b1;
      end else if (syn <= 4'd12) begin
        dec_corr               = 1'b1;
        fixed_cw[syn - 4'd1]   = ~in_cw[syn - 4'd1];
      end else begin
        dec_uncorr = 1'b1;
      end
    end else if (syn != 4'd0) begin
      dec_uncorr = 1'b1;
    end
  end

  assign dec_data = {fixed_cw[11], fixed_cw[10], fixed_cw[9], fixed_cw[8],
                     fixed_cw[6],  fixed_cw[5],  fixed_cw[4], fixed_cw[2]};

  assign in_ready = !out_valid_q || out_ready;
  assign take     = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (take) begin
      out_valid_d  = 1'b1;
      out_data_d   = dec_data;
      out_corr_d   = dec_corr;
      out_uncorr_d = dec_uncorr;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_corrected = out_corr_q;
  assign out_uncorr    = out_uncorr_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (take) begin
      if (dec_corr && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (dec_uncorr && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_13_8_decoder.sv
// Directed bench for hamming_13_8_decoder: vector table plus handshake, saturation and reset sequences.
module tb_hamming_13_8_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] in_cw;
  logic        in_valid, in_valid2;
  logic        out_ready;
  logic        cnt_clr, cnt_clr2;

  logic        in_ready, in_ready2;
  logic [7:0]  out_data, out_data2;
  logic        out_corrected, out_corrected2;
  logic        out_uncorr, out_uncorr2;
  logic        out_valid, out_valid2;
  logic [7:0]  corr_cnt, uncorr_cnt;
  logic [1:0]  corr_cnt2, uncorr_cnt2;

  always #5 clk = ~clk;

  hamming_13_8_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_cw(in_cw), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_13_8_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_cw(in_cw), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_corrected(out_corrected2), .out_uncorr(out_uncorr2),
    .out_valid(out_valid2), .out_ready(out_ready), .cnt_clr(cnt_clr2),
    .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  typedef struct {
    logic [12:0] cw;
    logic [7:0]  data;
    logic        corr;
    logic        uncorr;
  } vec_t;

  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;
  int   m_corr = 0;
  int   m_uncorr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int m, input int cap);
`ifdef HAMMING_ERR_CNT_EN
    return (m > cap) ? cap : m;
`else
    return 0;
`endif
  endfunction

  task automatic check_out(input string tag, input logic [7:0] d, input logic c, input logic u);
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " data"}, out_data, d);
    check({tag, " corr"}, out_corrected, c);
    check({tag, " uncorr"}, out_uncorr, u);
    check({tag, " excl"}, out_corrected & out_uncorr, 1'b0);
    check({tag, " corr_cnt"}, corr_cnt, cnt_exp(m_corr, 255));
    check({tag, " uncorr_cnt"}, uncorr_cnt, cnt_exp(m_uncorr, 255));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{13'h0000, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{13'h0004, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{13'h1000, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{13'h0003, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{13'h0F77, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{13'h0A27, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{13'h0A67, 8'hA5, 1'b1, 1'b0};
    vecs[7]  = '{13'h0A26, 8'hA5, 1'b1, 1'b0};
    vecs[8]  = '{13'h0777, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{13'h0F63, 8'hFC, 1'b0, 1'b1};
    vecs[10] = '{13'h0089, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{13'h008A, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{13'h008C, 8'h01, 1'b0, 1'b1};
    vecs[13] = '{13'h1007, 8'h01, 1'b0, 1'b0};
    vecs[14] = '{13'h0007, 8'h01, 1'b1, 1'b0};
    vecs[15] = '{13'h1FFF, 8'h7F, 1'b1, 1'b0};

    rst = 1'b1; in_cw = '0; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0; cnt_clr2 = 1'b0;
    #2;
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data", out_data, 8'h00);
    check("rst flags", {out_corrected, out_uncorr}, 2'b00);
    check("rst in_ready", in_ready, 1'b1);
    check("rst counters", {corr_cnt, uncorr_cnt}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    check("post-rst in_ready", in_ready, 1'b1);

    // Table: back-to-back transfers with no backpressure.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_cw    = vecs[i].cw;
      @(posedge clk);
      @(negedge clk);
      if (vecs[i].corr)   m_corr++;
      if (vecs[i].uncorr) m_uncorr++;
      check_out($sformatf("vec%0d", i), vecs[i].data, vecs[i].corr, vecs[i].uncorr);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drain out_valid", out_valid, 1'b0);

    // Backpressure: one word captured, then held for three stalled cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cw     = 13'h0F77;
    @(posedge clk);
    @(negedge clk);
    check_out("bp A", 8'hFF, 1'b0, 1'b0);
    check("bp in_ready c2", in_ready, 1'b0);
    in_cw = 13'h0A67;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("bp hold%0d", k), 8'hFF, 1'b0, 1'b0);
      check($sformatf("bp in_ready hold%0d", k), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready release", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    m_corr++;
    check_out("bp B", 8'hA5, 1'b1, 1'b0);
    in_cw = 13'h1007;
    @(posedge clk);
    @(negedge clk);
    check_out("bp C", 8'h01, 1'b0, 1'b0);
    in_cw = 13'h1FFF;
    @(posedge clk);
    @(negedge clk);
    m_corr++;
    check_out("bp D", 8'h7F, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp drain", out_valid, 1'b0);

    // Saturation and clear priority on the 2-bit counter instance.
    in_valid2 = 1'b1;
    in_cw     = 13'h0004;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat corr_cnt2 #%0d", k), corr_cnt2, cnt_exp(k, 3));
      check($sformatf("sat out_corr2 #%0d", k), out_corrected2, 1'b1);
    end
    cnt_clr2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("clr corr_cnt2", corr_cnt2, 2'd0);
    check("clr uncorr_cnt2", uncorr_cnt2, 2'd0);
    check("clr out_data2", out_data2, 8'h00);
    cnt_clr2  = 1'b0;
    in_valid2 = 1'b0;

    // Reset mid-stream while a result is held under backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cw     = 13'h0003;
    @(posedge clk);
    @(negedge clk);
    m_uncorr++;
    check_out("pre-rst", 8'h00, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    m_corr = 0;
    m_uncorr = 0;
    check("mid-rst out_valid", out_valid, 1'b0);
    check("mid-rst flags", {out_corrected, out_uncorr}, 2'b00);
    check("mid-rst counters", {corr_cnt, uncorr_cnt}, 16'h0000);
    check("mid-rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rel in_ready", in_ready, 1'b1);
    check("rel out_valid", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = 13'h0004;
    @(posedge clk);
    @(negedge clk);
    m_corr++;
    check_out("post-rst word", 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_13_8_decoder.md
HAMMING_13_8_DECODER -- requirements
Module: hamming_13_8_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each error counter (2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_cw  input  13  received codeword: in_cw[i-1] = Hamming position i (i=1..12); in_cw[12] = overall even parity over in_cw[11:0].
REQ-005 SHALL have port in_valid  input  1  in_cw valid this cycle.
REQ-006 SHALL have port in_ready  output  1  decoder accepts in_cw this cycle.
REQ-007 SHALL have port out_data  output  8  decoded data byte.
REQ-008 SHALL have port out_corrected  output  1  single error corrected (incl. parity-bit-only error).
REQ-009 SHALL have port out_uncorr  output  1  uncorrectable error detected.
REQ-010 SHALL have port out_valid  output  1  out_* holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-013 SHALL have ports corr_cnt and uncorr_cnt  output  CNT_W each  error counters.

Function
REQ-014 SHALL use check bits at positions 1,2,4,8; data d[0..7] at positions 3,5,6,7,9,10,11,12.
REQ-015 SHALL compute syndrome s[3:0] = XOR of indices of all set positions 1..12, and pe = XOR of in_cw[12:0].
REQ-016 SHALL classify: s=0,pe=0 -> clean; s=0,pe=1 -> corrected (cw[12] error, data unchanged); s in 1..12,pe=1 -> invert position s, corrected; s in 13..15,pe=1 -> uncorrectable; s!=0,pe=0 -> uncorrectable.
REQ-017 SHALL, on uncorrectable, output the raw uncorrected data bits with out_corrected=0.
REQ-018 SHALL never assert out_corrected and out_uncorr together.
REQ-019 SHALL register results in a single output stage: transfer when in_valid&&in_ready; result visible on out_* exactly 1 cycle later.
REQ-020 SHALL drive in_ready = !out_valid || out_ready (combinational; full throughput under no backpressure).
REQ-021 SHALL hold out_* stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after out_valid&&out_ready unless a new transfer occurs that same cycle (then load new result, out_valid stays 1).
REQ-023 SHALL ignore in_cw when in_valid=0 or in_ready=0.
REQ-024 SHALL increment corr_cnt/uncorr_cnt on the input transfer cycle of a corrected/uncorrectable word, saturating at 2^CNT_W-1.
REQ-025 SHALL give cnt_clr priority over a same-cycle increment (result 0).

Reset
REQ-026 SHALL, on rst, asynchronously set out_valid=0, out_data=0x00, out_corrected=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0; in-flight result discarded.
REQ-027 SHALL hold in_ready=1 while in reset and after release.

Configuration
REQ-028 SHALL include corr_cnt/uncorr_cnt logic only when HAMMING_ERR_CNT_EN is defined; otherwise both ports tie to 0, cnt_clr ignored, no counter flops.

Verification
REQ-029 SHALL cover: in_cw=13'h0000, out_ready=1 -> next cycle out_data=0x00, flags 0, counters unchanged.
REQ-030 SHALL cover: in_cw=13'h0004 (position 3 flipped) -> out_data=0x00, out_corrected=1, corr_cnt=1; in_cw=13'h1000 -> out_data=0x00, out_corrected=1, corr_cnt=2.
REQ-031 SHALL cover: in_cw=13'h0003 (positions 1,2) -> out_uncorr=1, out_corrected=0, out_data=0x00, uncorr_cnt=1.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 from cycle 2, out_* unchanged, one word accepted; out_ready=1 -> back-to-back transfers, none lost or duplicated.
REQ-033 SHALL cover: CNT_W=2, 5 corrected words -> corr_cnt saturates at 3; cnt_clr with a same-cycle corrected word -> corr_cnt=0.
REQ-034 SHALL cover: rst asserted mid-stream with out_valid=1 -> out_valid=0, counters 0 immediately, in_ready=1 after release; build without HAMMING_ERR_CNT_EN -> counters read 0.
